uncache_unit: RTL and testbench

UNCACHE_UNIT -- requirements
Module: uncache_unit

---
 rtl/uncache_unit.sv | 119 +++++++++++
 tb/tb_uncache_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_unit.sv
// Uncached data-side access unit: turns one held EX-stage load/store into a single bridge
// read or write transaction, stalling the pipeline until it completes.
module uncache_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        conv_en,
  input  logic [3:0]  conv_wen,
  input  logic [31:0] conv_addr,
  input  logic [31:0] conv_wdata,
  output logic [31:0] conv_rdata,
  output logic        stallreq_uncache,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [1:0]  rd_size,
  input  logic        rd_addr_ok,
  input  logic        ret_valid,
  input  logic [31:0] ret_data,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [1:0]  wr_size,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_data,
  input  logic        wr_addr_ok,
  input  logic        wr_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_addr;
  logic [3:0]  req_wen;
  logic [31:0] req_wdata;
  logic [31:0] rdata_q;
  logic        accept;

  assign accept = (state == IDLE) && conv_en;

  // Request fields are captured once at acceptance so the bridge sees them stable
  // regardless of what the pipeline does with the EX inputs afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_addr  <= 32'h0;
      req_wen   <= 4'h0;
      req_wdata <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr  <= conv_addr & 32'h1FFF_FFFF;
        req_wen   <= conv_wen;
        req_wdata <= conv_wdata;
      end
      if ((state == RD_WAIT) && ret_valid) begin
        rdata_q <= ret_data;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    rd_req           = 1'b0;
    wr_req           = 1'b0;
    stallreq_uncache = 1'b0;
    case (state)
      IDLE: begin
        stallreq_uncache = conv_en;
        if (conv_en) begin
          state_nxt = (conv_wen == 4'h0) ? RD_REQ : WR_REQ;
        end
      end
      RD_REQ: begin
        rd_req           = 1'b1;
        stallreq_uncache = 1'b1;
        if (rd_addr_ok) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        stallreq_uncache = 1'b1;
        if (ret_valid) state_nxt = DONE;
      end
      WR_REQ: begin
        wr_req           = 1'b1;
        stallreq_uncache = 1'b1;
        if (wr_addr_ok) state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        stallreq_uncache = 1'b1;
        if (wr_done) state_nxt = DONE;
      end
      // Stall drops for this single cycle so the held instruction retires exactly once.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (req_wen)
      4'b0011, 4'b1100:                   wr_size = 2'b01;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wr_size = 2'b00;
      default:                            wr_size = 2'b10;
    endcase
  end

  assign rd_addr    = {req_addr[31:2], 2'b00};
  assign rd_size    = 2'b10;
  assign wr_addr    = req_addr;
  assign wr_wstrb   = req_wen;
  assign wr_data    = req_wdata;
  assign conv_rdata = rdata_q;

endmodule

// File: tb/tb_uncache_unit.sv
// Bench for uncache_unit: directed vector table, hand-written reset/spurious/back-to-back
// sequences, and randomized transactions checked against a transaction-level model.
module tb_uncache_unit;

  logic        clk;
  logic        rst;
  logic        conv_en;
  logic [3:0]  conv_wen;
  logic [31:0] conv_addr;
  logic [31:0] conv_wdata;
  logic [31:0] conv_rdata;
  logic        stallreq_uncache;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_addr_ok;
  logic        ret_valid;
  logic [31:0] ret_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [1:0]  wr_size;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_data;
  logic        wr_addr_ok;
  logic        wr_done;

  uncache_unit dut (
    .clk              (clk),
    .rst              (rst),
    .conv_en          (conv_en),
    .conv_wen         (conv_wen),
    .conv_addr        (conv_addr),
    .conv_wdata       (conv_wdata),
    .conv_rdata       (conv_rdata),
    .stallreq_uncache (stallreq_uncache),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_size          (rd_size),
    .rd_addr_ok       (rd_addr_ok),
    .ret_valid        (ret_valid),
    .ret_data         (ret_data),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_size          (wr_size),
    .wr_wstrb         (wr_wstrb),
    .wr_data          (wr_data),
    .wr_addr_ok       (wr_addr_ok),
    .wr_done          (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] ret;
    int          ok_dly;
    int          rsp_dly;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
  } vec_t;

  int          checks = 0;
  int          passed = 0;
  int          hs_rd  = 0;
  logic [31:0] mdl_rdata;

  always @(posedge clk) begin
    if (rd_req && rd_addr_ok) hs_rd <= hs_rd + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Transaction-level reference: physical address and transfer size from the access itself.
  function automatic vec_t model_vec(input logic [31:0] addr, input logic [3:0] wen,
                                     input logic [31:0] wdata, input logic [31:0] ret,
                                     input int ok_dly, input int rsp_dly);
    vec_t v;
    v.addr = addr; v.wen = wen; v.wdata = wdata; v.ret = ret;
    v.ok_dly = ok_dly; v.rsp_dly = rsp_dly;
    v.exp_addr = addr % 32'h2000_0000;
    if (wen == 4'h0) begin
      v.exp_addr = (v.exp_addr / 4) * 4;
      v.exp_size = 2'd2;
    end else begin
      case ($countones(wen))
        1:       v.exp_size = 2'd0;
        2:       v.exp_size = 2'd1;
        default: v.exp_size = 2'd2;
      endcase
    end
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Entry and exit at one time unit after a rising edge with the unit idle.
  task automatic run_txn(input vec_t v, input bit keep_en, input logic [31:0] nxt_addr);
    bit is_rd;
    int stalls;
    is_rd  = (v.wen == 4'h0);
    stalls = 0;
    conv_en = 1'b1; conv_wen = v.wen; conv_addr = v.addr; conv_wdata = v.wdata;
    #1;
    if (stallreq_uncache) stalls++;
    cycle();
    conv_addr  = ~v.addr;
    conv_wdata = ~v.wdata;
    for (int i = 0; i <= v.ok_dly; i++) begin
      if (i == v.ok_dly) begin
        if (is_rd) rd_addr_ok = 1'b1;
        else       wr_addr_ok = 1'b1;
      end
      #1;
      if (stallreq_uncache) stalls++;
      if (is_rd) begin
        chk("rd_req_high", rd_req, 1);
        chk("rd_addr", rd_addr, v.exp_addr);
        chk("rd_size", rd_size, v.exp_size);
        chk("wr_req_low_in_read", wr_req, 0);
      end else begin
        chk("wr_req_high", wr_req, 1);
        chk("wr_addr", wr_addr, v.exp_addr);
        chk("wr_size", wr_size, v.exp_size);
        chk("wr_wstrb", wr_wstrb, v.wen);
        chk("wr_data", wr_data, v.wdata);
        chk("rd_req_low_in_write", rd_req, 0);
      end
      cycle();
    end
    rd_addr_ok = 1'b0; wr_addr_ok = 1'b0;
    for (int i = 0; i <= v.rsp_dly; i++) begin
      if (i == v.rsp_dly) begin
        if (is_rd) begin ret_valid = 1'b1; ret_data = v.ret; end
        else wr_done = 1'b1;
      end
      if (!is_rd) begin ret_valid = 1'b1; ret_data = $urandom; end
      #1;
      if (stallreq_uncache) stalls++;
      chk("wait_reqs_low", {rd_req, wr_req}, 0);
      chk("wait_rdata_hold", conv_rdata, mdl_rdata);
      cycle();
    end
    ret_valid = 1'b0; wr_done = 1'b0; ret_data = 32'h0;
    if (is_rd) mdl_rdata = v.ret;
    #1;
    chk("done_stall_low", stallreq_uncache, 0);
    chk("done_rdata", conv_rdata, mdl_rdata);
    chk("stall_cycles", stalls, 3 + v.ok_dly + v.rsp_dly);
    if (keep_en) begin
      conv_addr = nxt_addr; conv_wen = 4'h0;
    end else begin
      conv_en = 1'b0;
    end
    cycle();
    if (!keep_en) begin
      #1;
      chk("idle_stall_low", stallreq_uncache, 0);
      chk("idle_reqs_low", {rd_req, wr_req}, 0);
      chk("idle_rdata_hold", conv_rdata, mdl_rdata);
    end
  endtask

  vec_t tbl[7];
  logic [3:0] wen_pool[10];

  initial begin
    tbl[0] = '{32'hBFAF_F000, 4'b0000, 32'h0000_0000, 32'h1234_5678, 0, 0, 32'h1FAF_F000, 2'd2};
    tbl[1] = '{32'hBFAF_F003, 4'b1000, 32'hAB00_0000, 32'h0000_0000, 0, 2, 32'h1FAF_F003, 2'd0};
    tbl[2] = '{32'hBFC0_0006, 4'b0000, 32'h0000_0000, 32'h8765_4321, 5, 1, 32'h1FC0_0004, 2'd2};
    tbl[3] = '{32'hA000_0102, 4'b0011, 32'h0000_BEEF, 32'h0000_0000, 0, 0, 32'h0000_0102, 2'd1};
    tbl[4] = '{32'hBFAF_FFF8, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1, 3, 32'h1FAF_FFF8, 2'd2};
    tbl[5] = '{32'hB000_0001, 4'b0010, 32'h0000_5A00, 32'h0000_0000, 0, 1, 32'h1000_0001, 2'd0};
    tbl[6] = '{32'h8000_0003, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 2, 0, 32'h0000_0000, 2'd2};
    wen_pool = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    rst = 1'b0; conv_en = 1'b0; conv_wen = 4'h0; conv_addr = 32'h0; conv_wdata = 32'h0;
    rd_addr_ok = 1'b0; ret_valid = 1'b0; ret_data = 32'h0; wr_addr_ok = 1'b0; wr_done = 1'b0;
    mdl_rdata = 32'h0;
    #1;
    chk("reset_stall", stallreq_uncache, 0);
    chk("reset_reqs", {rd_req, wr_req}, 0);
    chk("reset_rdata", conv_rdata, 0);
    chk("reset_latched", {wr_addr, wr_wstrb, wr_data}, 0);
    conv_en = 1'b1;
    #1;
    chk("reset_stall_idle_rule", stallreq_uncache, 1);
    conv_en = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0, 32'h0);

    // Back-to-back reads: the second request only starts after DONE has retired the first.
    begin
      int hs0;
      vec_t a;
      vec_t b;
      hs0 = hs_rd;
      a = model_vec(32'hBFAF_F010, 4'h0, 32'h0, 32'h1111_2222, 0, 0);
      b = model_vec(32'hBFAF_F014, 4'h0, 32'h0, 32'h3333_4444, 0, 1);
      run_txn(a, 1'b1, b.addr);
      run_txn(b, 1'b0, 32'h0);
      chk("b2b_handshakes", hs_rd - hs0, 2);
    end

    // Spurious bridge activity while idle must be ignored.
    conv_en = 1'b0; wr_done = 1'b1; ret_valid = 1'b1; ret_data = 32'hFFFF_0000;
    rd_addr_ok = 1'b1; wr_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("spur_stall", stallreq_uncache, 0);
      chk("spur_reqs", {rd_req, wr_req}, 0);
      chk("spur_rdata", conv_rdata, mdl_rdata);
      cycle();
    end
    wr_done = 1'b0; ret_valid = 1'b0; ret_data = 32'h0; rd_addr_ok = 1'b0; wr_addr_ok = 1'b0;
    run_txn(model_vec(32'hBFAF_F020, 4'h0, 32'h0, 32'h0BAD_F00D, 0, 0), 1'b0, 32'h0);

    // Reset while waiting for read data abandons the transaction.
    conv_en = 1'b1; conv_wen = 4'h0; conv_addr = 32'hBFAF_F030;
    cycle();
    rd_addr_ok = 1'b1;
    cycle();
    rd_addr_ok = 1'b0; conv_en = 1'b0;
    #1;
    chk("rst_mid_in_wait_stall", stallreq_uncache, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", stallreq_uncache, 0);
    chk("rst_mid_rdata", conv_rdata, 0);
    chk("rst_mid_reqs", {rd_req, wr_req}, 0);
    mdl_rdata = 32'h0;
    cycle();
    rst = 1'b1; ret_valid = 1'b1; ret_data = 32'h5555_AAAA;
    cycle();
    ret_valid = 1'b0; ret_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_late_ret_rdata", conv_rdata, 0);
      chk("rst_no_reissue_stall", stallreq_uncache, 0);
      chk("rst_no_reissue_reqs", {rd_req, wr_req}, 0);
      cycle();
    end

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v = model_vec($urandom, wen_pool[$urandom_range(0, 9)], $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
      run_txn(v, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
